// File: rtl/display_scan_controller.sv
// Time-multiplexed scan controller for a 4-digit seven-segment decoder stage.
// Display content is snapshotted once per frame so no digit changes mid-scan.
module display_scan_controller #(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLINK_FRAMES = 125
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_mask,
  input  logic [3:0]  blink_mask,
  input  logic        blank_lead,
  output logic [3:0]  x,
  output logic [1:0]  sw,
  output logic        dec,
  output logic        enable,
  output logic        frame_start
);

  localparam int unsigned TICK_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(REFRESH_DIV - 1);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(BLINK_FRAMES - 1);

  logic [TICK_W-1:0] tick;
  logic [1:0]        sel;
  logic [FCNT_W-1:0] fcnt;
  logic              blink_phase;
  logic              load_pending;
  logic [15:0]       sh_digits;
  logic [3:0]        sh_dp;
  logic [3:0]        sh_blink;
  logic              sh_blank_lead;

  logic step_c;
  logic frame_wrap_c;

  assign step_c       = (tick == TICK_LAST);
  assign frame_wrap_c = step_c && (sel == 2'd3);

  // Slot/frame sequencing and per-frame snapshot of display content
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick          <= '0;
      sel           <= '0;
      fcnt          <= '0;
      blink_phase   <= 1'b0;
      load_pending  <= 1'b1;
      frame_start   <= 1'b0;
      sh_digits     <= '0;
      sh_dp         <= '0;
      sh_blink      <= '0;
      sh_blank_lead <= 1'b0;
    end else if (load_pending) begin
      // First edge after reset: capture content, keep tick parked at slot 0 start
      load_pending  <= 1'b0;
      frame_start   <= 1'b1;
      sh_digits     <= digits;
      sh_dp         <= dp_mask;
      sh_blink      <= blink_mask;
      sh_blank_lead <= blank_lead;
    end else begin
      frame_start <= frame_wrap_c;
      if (step_c) begin
        tick <= '0;
        sel  <= sel + 2'd1;
      end else begin
        tick <= tick + TICK_W'(1);
      end
      if (frame_wrap_c) begin
        sh_digits     <= digits;
        sh_dp         <= dp_mask;
        sh_blink      <= blink_mask;
        sh_blank_lead <= blank_lead;
        if (fcnt == FCNT_LAST) begin
          fcnt        <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          fcnt <= fcnt + FCNT_W'(1);
        end
      end
    end
  end

  // Per-slot decoder drive, derived only from registered state
  always_comb begin
    x = sh_digits[3:0];
    unique case (sel)
      2'd0: x = sh_digits[3:0];
      2'd1: x = sh_digits[7:4];
      2'd2: x = sh_digits[11:8];
      2'd3: x = sh_digits[15:12];
      default: x = sh_digits[3:0];
    endcase
    sw     = sel;
    dec    = ~sh_dp[sel];
    enable = 1'b1;
    if (load_pending) begin
      enable = 1'b0;
    end else if (blink_phase && sh_blink[sel]) begin
      enable = 1'b0;
    end else if (sh_blank_lead && (sel == 2'd3) && (sh_digits[15:12] == 4'd0)) begin
      enable = 1'b0;
    end
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller: table-driven scan/snapshot/blink
// vectors plus hand sequences for async reset and the single-cycle-slot case.
module tb_display_scan_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] digits;
  logic [3:0]  dp_mask, blink_mask;
  logic        blank_lead;
  logic [3:0]  x;
  logic [1:0]  sw;
  logic        dec, enable, frame_start;

  logic        reset1;
  logic [15:0] digits1;
  logic [3:0]  dp_mask1, blink_mask1;
  logic        blank_lead1;
  logic [3:0]  x1;
  logic [1:0]  sw1;
  logic        dec1, enable1, frame_start1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  display_scan_controller #(.REFRESH_DIV(4), .BLINK_FRAMES(2)) dut (
    .clk(clk), .reset(reset), .digits(digits), .dp_mask(dp_mask),
    .blink_mask(blink_mask), .blank_lead(blank_lead), .x(x), .sw(sw),
    .dec(dec), .enable(enable), .frame_start(frame_start)
  );

  display_scan_controller #(.REFRESH_DIV(1), .BLINK_FRAMES(1)) dut1 (
    .clk(clk), .reset(reset1), .digits(digits1), .dp_mask(dp_mask1),
    .blink_mask(blink_mask1), .blank_lead(blank_lead1), .x(x1), .sw(sw1),
    .dec(dec1), .enable(enable1), .frame_start(frame_start1)
  );

  typedef struct {
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  bm;
    logic        bl;
    int          adv;
    logic [3:0]  ex;
    logic [1:0]  esw;
    logic        edec;
    logic        een;
    logic        efs;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bm,
                     input logic bl, input int adv, input logic [3:0] ex,
                     input logic [1:0] esw, input logic edec, input logic een,
                     input logic efs);
    vec_t v;
    v.digits = d; v.dp = dp; v.bm = bm; v.bl = bl; v.adv = adv;
    v.ex = ex; v.esw = esw; v.edec = edec; v.een = een; v.efs = efs;
    vq.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare packed {x, sw, dec, enable, frame_start}
  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got x=%h sw=%0d dec=%b en=%b fs=%b, expected x=%h sw=%0d dec=%b en=%b fs=%b",
               name, act[8:5], act[4:3], act[2], act[1], act[0],
               exp[8:5], exp[4:3], exp[2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [8:0] pk(input logic [3:0] a, input logic [1:0] b,
                                    input logic c, input logic d, input logic e);
    return {a, b, c, d, e};
  endfunction

  initial begin
    reset = 1'b1; digits = 16'h1234; dp_mask = 4'h0; blink_mask = 4'h0; blank_lead = 1'b0;
    reset1 = 1'b1; digits1 = 16'hABCD; dp_mask1 = 4'h0; blink_mask1 = 4'b0001; blank_lead1 = 1'b0;

    // Cycle numbers in comments count from the first cycle after the load edge
    add(16'h1234, 4'h0, 4'h0, 1'b0, 1, 4'h4, 2'd0, 1'b1, 1'b1, 1'b1); // c0 load
    add(16'h1234, 4'h0, 4'h0, 1'b0, 1, 4'h4, 2'd0, 1'b1, 1'b1, 1'b0); // c1
    add(16'h1234, 4'h0, 4'h0, 1'b0, 3, 4'h3, 2'd1, 1'b1, 1'b1, 1'b0); // c4
    add(16'h1234, 4'h0, 4'h0, 1'b0, 4, 4'h2, 2'd2, 1'b1, 1'b1, 1'b0); // c8
    add(16'h1234, 4'h0, 4'h0, 1'b0, 4, 4'h1, 2'd3, 1'b1, 1'b1, 1'b0); // c12
    add(16'h1234, 4'h0, 4'h0, 1'b0, 3, 4'h1, 2'd3, 1'b1, 1'b1, 1'b0); // c15
    add(16'h1234, 4'h0, 4'h0, 1'b0, 1, 4'h4, 2'd0, 1'b1, 1'b1, 1'b1); // c16 frame1
    add(16'h1234, 4'h0, 4'h0, 1'b0, 4, 4'h3, 2'd1, 1'b1, 1'b1, 1'b0); // c20
    add(16'h5678, 4'h0, 4'h0, 1'b0, 4, 4'h2, 2'd2, 1'b1, 1'b1, 1'b0); // c24 new digits hidden
    add(16'h5678, 4'h0, 4'h0, 1'b0, 4, 4'h1, 2'd3, 1'b1, 1'b1, 1'b0); // c28
    add(16'h5678, 4'h0, 4'h0, 1'b0, 4, 4'h8, 2'd0, 1'b1, 1'b1, 1'b1); // c32 frame2
    add(16'h5678, 4'h0, 4'h0, 1'b0, 1, 4'h8, 2'd0, 1'b1, 1'b1, 1'b0); // c33
    add(16'h5678, 4'h0, 4'h0, 1'b0, 3, 4'h7, 2'd1, 1'b1, 1'b1, 1'b0); // c36
    add(16'h5678, 4'h0, 4'h0, 1'b0, 4, 4'h6, 2'd2, 1'b1, 1'b1, 1'b0); // c40
    add(16'h5678, 4'h0, 4'h0, 1'b0, 4, 4'h5, 2'd3, 1'b1, 1'b1, 1'b0); // c44
    add(16'h5678, 4'h0, 4'h3, 1'b0, 4, 4'h8, 2'd0, 1'b1, 1'b0, 1'b1); // c48 frame3 phase1
    add(16'h5678, 4'h0, 4'h3, 1'b0, 4, 4'h7, 2'd1, 1'b1, 1'b0, 1'b0); // c52
    add(16'h5678, 4'h0, 4'h3, 1'b0, 4, 4'h6, 2'd2, 1'b1, 1'b1, 1'b0); // c56
    add(16'h5678, 4'h0, 4'h3, 1'b0, 4, 4'h5, 2'd3, 1'b1, 1'b1, 1'b0); // c60
    add(16'h5678, 4'h0, 4'h3, 1'b0, 4, 4'h8, 2'd0, 1'b1, 1'b1, 1'b1); // c64 frame4 phase0
    add(16'h5678, 4'h0, 4'h3, 1'b0, 4, 4'h7, 2'd1, 1'b1, 1'b1, 1'b0); // c68
    add(16'h5678, 4'h0, 4'h3, 1'b0, 12, 4'h8, 2'd0, 1'b1, 1'b1, 1'b1); // c80 frame5 phase0
    add(16'h5678, 4'h0, 4'h3, 1'b0, 16, 4'h8, 2'd0, 1'b1, 1'b0, 1'b1); // c96 frame6 phase1
    add(16'h5678, 4'h0, 4'h3, 1'b0, 20, 4'h7, 2'd1, 1'b1, 1'b0, 1'b0); // c116 frame7
    add(16'h0945, 4'h0, 4'h0, 1'b1, 12, 4'h5, 2'd0, 1'b1, 1'b1, 1'b1); // c128 frame8
    add(16'h0945, 4'h0, 4'h0, 1'b1, 4, 4'h4, 2'd1, 1'b1, 1'b1, 1'b0); // c132
    add(16'h0945, 4'h0, 4'h0, 1'b1, 4, 4'h9, 2'd2, 1'b1, 1'b1, 1'b0); // c136
    add(16'h0945, 4'h0, 4'h0, 1'b1, 4, 4'h0, 2'd3, 1'b1, 1'b0, 1'b0); // c140 leading blank
    add(16'h0945, 4'h0, 4'h0, 1'b0, 4, 4'h5, 2'd0, 1'b1, 1'b1, 1'b1); // c144 frame9
    add(16'h0945, 4'h0, 4'h0, 1'b0, 12, 4'h0, 2'd3, 1'b1, 1'b1, 1'b0); // c156 zero shown
    add(16'h0945, 4'h4, 4'h0, 1'b0, 4, 4'h5, 2'd0, 1'b1, 1'b1, 1'b1); // c160 frame10
    add(16'h0945, 4'h4, 4'h0, 1'b0, 4, 4'h4, 2'd1, 1'b1, 1'b1, 1'b0); // c164
    add(16'h0945, 4'h4, 4'h0, 1'b0, 4, 4'h9, 2'd2, 1'b0, 1'b1, 1'b0); // c168 dp lit
    add(16'h0945, 4'h4, 4'h0, 1'b0, 3, 4'h9, 2'd2, 1'b0, 1'b1, 1'b0); // c171
    add(16'h0945, 4'h4, 4'h0, 1'b0, 1, 4'h0, 2'd3, 1'b1, 1'b1, 1'b0); // c172

    step(); step();
    check("in_reset", pk(x, sw, dec, enable, frame_start), pk(4'h0, 2'd0, 1'b1, 1'b0, 1'b0));
    check("in_reset_r1", pk(x1, sw1, dec1, enable1, frame_start1), pk(4'h0, 2'd0, 1'b1, 1'b0, 1'b0));
    reset = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      digits = vq[i].digits; dp_mask = vq[i].dp; blink_mask = vq[i].bm; blank_lead = vq[i].bl;
      repeat (vq[i].adv) step();
      check($sformatf("vec%0d", i), pk(x, sw, dec, enable, frame_start),
            pk(vq[i].ex, vq[i].esw, vq[i].edec, vq[i].een, vq[i].efs));
    end

    // Async reset between edges while scanning slot 2 (c184)
    repeat (12) step();
    check("pre_reset", pk(x, sw, dec, enable, frame_start), pk(4'h9, 2'd2, 1'b0, 1'b1, 1'b0));
    #2 reset = 1'b1;
    #1 check("async_reset", pk(x, sw, dec, enable, frame_start), pk(4'h0, 2'd0, 1'b1, 1'b0, 1'b0));
    step(); step();
    check("held_reset", pk(x, sw, dec, enable, frame_start), pk(4'h0, 2'd0, 1'b1, 1'b0, 1'b0));
    digits = 16'h1234; dp_mask = 4'h0; blank_lead = 1'b0;
    reset = 1'b0;
    step();
    check("reload", pk(x, sw, dec, enable, frame_start), pk(4'h4, 2'd0, 1'b1, 1'b1, 1'b1));
    repeat (4) step();
    check("rescan", pk(x, sw, dec, enable, frame_start), pk(4'h3, 2'd1, 1'b1, 1'b1, 1'b0));

    // Single-cycle slots with a blink toggle on every frame
    reset1 = 1'b0;
    step();
    check("r1_load", pk(x1, sw1, dec1, enable1, frame_start1), pk(4'hD, 2'd0, 1'b1, 1'b1, 1'b1));
    step();
    check("r1_s1", pk(x1, sw1, dec1, enable1, frame_start1), pk(4'hC, 2'd1, 1'b1, 1'b1, 1'b0));
    step();
    check("r1_s2", pk(x1, sw1, dec1, enable1, frame_start1), pk(4'hB, 2'd2, 1'b1, 1'b1, 1'b0));
    step();
    check("r1_s3", pk(x1, sw1, dec1, enable1, frame_start1), pk(4'hA, 2'd3, 1'b1, 1'b1, 1'b0));
    step();
    check("r1_f1_blink", pk(x1, sw1, dec1, enable1, frame_start1), pk(4'hD, 2'd0, 1'b1, 1'b0, 1'b1));
    step();
    check("r1_f1_s1", pk(x1, sw1, dec1, enable1, frame_start1), pk(4'hC, 2'd1, 1'b1, 1'b1, 1'b0));
    repeat (3) step();
    check("r1_f2", pk(x1, sw1, dec1, enable1, frame_start1), pk(4'hD, 2'd0, 1'b1, 1'b1, 1'b1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
